alu_sequencer: RTL and testbench
================================

# alu_sequencer

Sequencer placed between the board inputs (switches, one "next" button) and the ALU, replacing the three per-operand load buttons with a single button.
- Each debounced press advances a state machine through operand A, opcode and operand B.
- In each load state the block drives the registered switch value onto the ALU data bus and pulses the matching ALU enable for one cycle.
- It rejects unknown opcodes, then latches the ALU result onto the LEDs.

## Interface
Parameters:
- CANT_SWITCHES, 4, width of switch input and ALU data bus
- CANT_LEDS, 4, width of ALU result and LED output
- CANT_BOTONES, 4, width of ALU enable bus (bit0 A, bit1 opcode, bit2 B, bit3 unused, held 0)
- DEBOUNCE_CYCLES, 16, stable cycles required to accept a button level change (used only with DEBOUNCE_EN)

Ports:
- i_clock  in  1  system clock; all logic on its rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_switch  in  CANT_SWITCHES  operand/opcode switches, asynchronous to i_clock
- i_next  in  1  advance button, asynchronous, active-high
- i_alu_result  in  CANT_LEDS  ALU result, combinational from the ALU's registered operands
- o_alu_data  out  CANT_SWITCHES  registered switch snapshot driven to the ALU data input
- o_alu_enable  out  CANT_BOTONES  one-hot load pulses to the ALU
- o_leds  out  CANT_LEDS  latched result
- o_error  out  1  invalid opcode flag
- o_done  out  1  one-cycle pulse when o_leds updates

## Operation
- Reset (i_reset=0, asynchronous): all outputs 0, state LOAD_A, debounce/sync state cleared, stable button level 0.
- Press event: a single-cycle pulse on the rising edge of the conditioned button level. A held button gives exactly one event.
- States:
  - LOAD_A: on event, o_alu_data<=i_switch, o_alu_enable<=0001 for one cycle, go to LOAD_OP.
  - LOAD_OP: on event, if i_switch is one of {1000 ADD, 1010 SUB, 1100 AND, 1101 OR, 1110 XOR, 0011 SRA, 0010 SRL, 1111 NOR}: o_alu_data<=i_switch, enable 0010 pulse, o_error<=0, go to LOAD_B. Otherwise: o_error<=1, no enable pulse, o_alu_data unchanged, stay in LOAD_OP.
  - LOAD_B: on event, o_alu_data<=i_switch, enable 0100 pulse, go to WAIT.
  - WAIT: one cycle, unconditional. Capture o_leds<=i_alu_result at the end of this cycle, go to SHOW.
  - SHOW: o_done pulses in the first cycle. o_leds holds. On event, go to LOAD_A; that event does not load A.
- Events arriving while in WAIT are dropped.
- o_alu_data holds its last value between loads.
- o_leds changes only on capture or reset.
- Opcode check uses the low 4 bits. If CANT_SWITCHES>4, upper bits must be 0 for a valid opcode.

## Timing
- Event in cycle N: the enable pulse and the new o_alu_data are both visible in cycle N+1, for exactly one cycle. The state changes at the same edge.
- B enable in cycle M: WAIT in M+1, o_leds valid and o_done=1 in M+2.
- i_next passes through a 2-flop synchronizer before edge detection, giving event latency ≥3 edges from i_next high.
- i_switch is sampled in the event cycle; switches must be stable by then.
- Reset asserted mid-transaction aborts immediately. After release, the FSM starts at LOAD_A; ALU-side registers are not cleared by this block.

## Configuration
- ALU_SEQ_DEBOUNCE_EN defined:
  - The synchronized level must differ from the stable level for DEBOUNCE_CYCLES consecutive cycles before the stable level updates.
  - The counter restarts on any bounce.
  - Event latency is 2 + DEBOUNCE_CYCLES + 1 edges.
- Undefined: the stable level is the synchronizer output; event latency is 3 edges, and there is no glitch rejection.

## Test plan
Bench connects a behavioural ALU model to o_alu_data/o_alu_enable/i_alu_result. Each press is held 40 cycles, then released for 40.
- ADD: presses with switches 0101, 1000, 0101 -> enables 0001, 0010, 0100 each high one cycle; o_leds=1010 and o_done pulse 2 cycles after the B enable.
- SUB: presses 0101, 1010, 0001 -> o_leds=0100; o_error stays 0.
- Invalid opcode: A=1101, opcode 0000 -> o_error=1, no enable pulse, still LOAD_OP. Press 1100 -> o_error=0, enable 0010. B=0101 -> o_leds=0101.
- Held button: i_next high for 200 cycles in LOAD_A -> exactly one 0001 pulse.
- Debounce (macro on, DEBOUNCE_CYCLES=16): a 5-cycle high glitch on i_next -> no event. A 20-cycle high level -> one event.
- Reset mid-operation: assert i_reset=0 in LOAD_B -> outputs 0 immediately. After release, the full ADD sequence yields 1010.

Source files
------------

// File: rtl/alu_sequencer.sv
// Single-button sequencer: loads ALU operand A, opcode and operand B, then latches the result onto the LEDs.
// Optional switch debounce on the advance button is enabled by defining ALU_SEQ_DEBOUNCE_EN.
module alu_sequencer #(
    parameter int CANT_SWITCHES   = 4,
    parameter int CANT_LEDS       = 4,
    parameter int CANT_BOTONES    = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [CANT_SWITCHES-1:0] i_switch,
    input  logic                     i_next,
    input  logic [CANT_LEDS-1:0]     i_alu_result,
    output logic [CANT_SWITCHES-1:0] o_alu_data,
    output logic [CANT_BOTONES-1:0]  o_alu_enable,
    output logic [CANT_LEDS-1:0]     o_leds,
    output logic                     o_error,
    output logic                     o_done
);

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_OP,
        LOAD_B,
        WAIT_RES,
        SHOW
    } state_t;

    localparam logic [CANT_BOTONES-1:0] EN_A  = CANT_BOTONES'(1);
    localparam logic [CANT_BOTONES-1:0] EN_OP = CANT_BOTONES'(2);
    localparam logic [CANT_BOTONES-1:0] EN_B  = CANT_BOTONES'(4);

    if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    state_t     state;
    logic [1:0] sync_q;
    logic       stable_q;
    logic       stable_d;
    logic       press;
    logic       op_valid;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync_q   <= '0;
            stable_d <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], i_next};
            stable_d <= stable_q;
        end
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CNT_W-1:0] db_cnt;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            db_cnt   <= '0;
            stable_q <= 1'b0;
        end else if (sync_q[1] == stable_q) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_q <= sync_q[1];
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end
`else
    assign stable_q = sync_q[1];
`endif

    assign press = stable_q & ~stable_d;

    always_comb begin
        op_valid = 1'b0;
        case (i_switch[3:0])
            4'b1000, 4'b1010, 4'b1100, 4'b1101,
            4'b1110, 4'b0011, 4'b0010, 4'b1111: op_valid = 1'b1;
            default:                            op_valid = 1'b0;
        endcase
        if ((i_switch >> 4) != '0) op_valid = 1'b0;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state        <= LOAD_A;
            o_alu_data   <= '0;
            o_alu_enable <= '0;
            o_leds       <= '0;
            o_error      <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_alu_enable <= '0;
            o_done       <= 1'b0;
            case (state)
                LOAD_A: if (press) begin
                    o_alu_data   <= i_switch;
                    o_alu_enable <= EN_A;
                    state        <= LOAD_OP;
                end
                LOAD_OP: if (press) begin
                    if (op_valid) begin
                        o_alu_data   <= i_switch;
                        o_alu_enable <= EN_OP;
                        o_error      <= 1'b0;
                        state        <= LOAD_B;
                    end else begin
                        o_error <= 1'b1;
                    end
                end
                LOAD_B: if (press) begin
                    o_alu_data   <= i_switch;
                    o_alu_enable <= EN_B;
                    state        <= WAIT_RES;
                end
                // B pulse cycle is spent here too: the ALU registers B at its end,
                // so the result is captured one cycle later.
                WAIT_RES: if (!o_alu_enable[2]) begin
                    o_leds <= i_alu_result;
                    o_done <= 1'b1;
                    state  <= SHOW;
                end
                SHOW: if (press) state <= LOAD_A;
                default: state <= LOAD_A;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized bench for alu_sequencer with a behavioural ALU and a press-level reference model.
// Debounce scenarios run only when ALU_SEQ_DEBOUNCE_EN is defined.
module tb_alu_sequencer;

    localparam int DB = 16;
`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam bit DB_ON = 1'b1;
`else
    localparam bit DB_ON = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw    = '0;
    logic       nxt   = 1'b0;
    logic [3:0] alu_res;
    logic [3:0] alu_data;
    logic [3:0] alu_en;
    logic [3:0] leds;
    logic       err;
    logic       done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_sequencer #(
        .CANT_SWITCHES  (4),
        .CANT_LEDS      (4),
        .CANT_BOTONES   (4),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_switch    (sw),
        .i_next      (nxt),
        .i_alu_result(alu_res),
        .o_alu_data  (alu_data),
        .o_alu_enable(alu_en),
        .o_leds      (leds),
        .o_error     (err),
        .o_done      (done)
    );

    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] op, input logic [3:0] b);
        case (op)
            4'h8:    return a + b;
            4'hA:    return a - b;
            4'hC:    return a & b;
            4'hD:    return a | b;
            4'hE:    return a ^ b;
            4'h3:    return 4'($signed(a) >>> b);
            4'h2:    return a >> b;
            4'hF:    return ~(a | b);
            default: return 4'h0;
        endcase
    endfunction

    function automatic bit op_ok(input logic [3:0] op);
        return op inside {4'h8, 4'hA, 4'hC, 4'hD, 4'hE, 4'h3, 4'h2, 4'hF};
    endfunction

    // Behavioural ALU: registers each field on its enable, result is combinational.
    logic [3:0] ra = '0, rop = '0, rb = '0;
    always @(posedge clk) begin
        if (alu_en[0]) ra  <= alu_data;
        if (alu_en[1]) rop <= alu_data;
        if (alu_en[2]) rb  <= alu_data;
    end
    assign alu_res = alu_f(ra, rop, rb);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference model: button history per clock edge, sequencing at press granularity.
    bit         smp [0:65535];
    int         cyc = 0, base = 0, ph = 0, cap_at = -1;
    bit         lvl = 1'b0, act_next = 1'b0, act, all_diff;
    logic [3:0] m_a = '0, m_op = '0, m_b = '0;
    logic [3:0] exp_data = '0, exp_en = '0, exp_leds = '0;
    logic       exp_err = 1'b0, exp_done = 1'b0;

    function automatic bit s(input int i);
        return (i <= base) ? 1'b0 : smp[i];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_data = '0; exp_en = '0; exp_leds = '0; exp_err = 1'b0; exp_done = 1'b0;
            ph = 0; lvl = 1'b0; act_next = 1'b0; cap_at = -1; base = cyc;
        end else begin
            cyc++;
            smp[cyc] = nxt;
            exp_en   = '0;
            exp_done = 1'b0;
            if (DB_ON) begin
                act      = act_next;
                act_next = 1'b0;
                all_diff = 1'b1;
                for (int k = 2; k <= DB + 1; k++) if (s(cyc - k) == lvl) all_diff = 1'b0;
                if (all_diff) begin
                    lvl = ~lvl;
                    if (lvl) act_next = 1'b1;
                end
            end else begin
                act = s(cyc - 2) && !s(cyc - 3);
            end
            if (ph == 3) begin
                if (cyc == cap_at) begin
                    exp_leds = alu_f(m_a, m_op, m_b);
                    exp_done = 1'b1;
                    ph = 4;
                end
            end else if (act) begin
                case (ph)
                    0: begin exp_data = sw; exp_en = 4'b0001; m_a = sw; ph = 1; end
                    1: if (op_ok(sw)) begin
                           exp_data = sw; exp_en = 4'b0010; exp_err = 1'b0; m_op = sw; ph = 2;
                       end else begin
                           exp_err = 1'b1;
                       end
                    2: begin exp_data = sw; exp_en = 4'b0100; m_b = sw; ph = 3; cap_at = cyc + 2; end
                    default: ph = 0;
                endcase
            end
        end
    end

    int n_a = 0, n_op = 0, n_done = 0;
    always @(negedge clk) begin
        chk("alu_enable", alu_en, exp_en);
        chk("alu_data", alu_data, exp_data);
        chk("leds", leds, exp_leds);
        chk("error", err, exp_err);
        chk("done", done, exp_done);
        if (alu_en == 4'b0001) n_a++;
        if (alu_en == 4'b0010) n_op++;
        if (done) n_done++;
    end

    task automatic press_for(input logic [3:0] v, input int hold);
        sw  = v;
        nxt = 1'b1;
        repeat (hold) @(posedge clk);
        #1 nxt = 1'b0;
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] v);
        press_for(v, 40);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_data"}, alu_data, 4'h0);
        chk({nm, "_en"}, alu_en, 4'h0);
        chk({nm, "_leds"}, leds, 4'h0);
        chk({nm, "_err"}, err, 1'b0);
        chk({nm, "_done"}, done, 1'b0);
    endtask

    logic [3:0] ops [8] = '{4'h8, 4'hA, 4'hC, 4'hD, 4'hE, 4'h3, 4'h2, 4'hF};
    logic [3:0] ra_v, op_v, rb_v;
    int         n0;

    initial begin
        @(posedge clk);
        #1 check_zero("reset");
        #17 rst_n = 1'b1;
        @(posedge clk);
        #1;

        n0 = n_done;
        press(4'b0101); press(4'b1000); press(4'b0101);
        chk("add_leds", leds, 4'b1010);
        chk("add_done_count", n_done - n0, 1);
        press(4'h0);

        press(4'b0101); press(4'b1010); press(4'b0001);
        chk("sub_leds", leds, 4'b0100);
        chk("sub_err", err, 1'b0);
        press(4'h0);

        press(4'b1101);
        n0 = n_op;
        press(4'b0000);
        chk("bad_op_err", err, 1'b1);
        chk("bad_op_no_pulse", n_op - n0, 0);
        press(4'b1100);
        chk("good_op_err", err, 1'b0);
        chk("good_op_pulse", n_op - n0, 1);
        press(4'b0101);
        chk("and_leds", leds, 4'b0101);
        press(4'h0);

        n0 = n_a;
        press_for(4'h3, 200);
        chk("held_one_pulse", n_a - n0, 1);
        press(4'h8); press(4'h1);
        chk("held_leds", leds, 4'h4);
        press(4'h0);

        if (DB_ON) begin
            n0  = n_a;
            sw  = 4'h6;
            nxt = 1'b1;
            repeat (5) @(posedge clk);
            #1 nxt = 1'b0;
            repeat (40) @(posedge clk);
            #1 chk("glitch_no_event", n_a - n0, 0);
            press_for(4'h6, 20);
            chk("level_one_event", n_a - n0, 1);
            press(4'h8); press(4'h1);
            chk("db_leds", leds, 4'h7);
            press(4'h0);
        end

        press(4'h5); press(4'h8);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("midreset");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        press(4'b0101); press(4'b1000); press(4'b0101);
        chk("post_reset_leds", leds, 4'b1010);
        press(4'h0);

        for (int t = 0; t < 25; t++) begin
            ra_v = 4'($urandom_range(0, 15));
            op_v = 4'($urandom_range(0, 15));
            rb_v = 4'($urandom_range(0, 15));
            press(ra_v);
            if (!op_ok(op_v)) begin
                press(op_v);
                chk("rand_bad_op_err", err, 1'b1);
                op_v = ops[$urandom_range(0, 7)];
            end
            press(op_v);
            press(rb_v);
            chk("rand_leds", leds, 32'(alu_f(ra_v, op_v, rb_v)));
            press(4'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
